// File: rtl/hlsm_if_param.sv
// Six-state HLSM: captures three signed operands and a mode on Start, then
// computes z = zrin + a*c and x = a*c - (a+b), with zrin chosen by a signed compare.
module hlsm_if_param #(
  parameter int WIDTH   = 32,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic [1:0]              Mode,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  output logic                    Busy,
  output logic                    Done,
  output logic signed [WIDTH-1:0] z,
  output logic signed [WIDTH-1:0] x
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    T1    = 3'd1,
    T2    = 3'd2,
    T3    = 3'd3,
    T4    = 3'd4,
    FINAL = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] a_q, b_q, c_q;
  logic [1:0]              mode_q;
  logic signed [WIDTH-1:0] d_q, f_q, zrin_q, z_q, x_q;
  logic                    g_q, done_q;

  logic accept, in_t1, in_t2, in_t3, in_t4, in_final;

  function automatic logic cond(input logic [1:0] m,
                                input logic signed [WIDTH-1:0] lhs,
                                input logic signed [WIDTH-1:0] rhs);
    logic r;
    case (m)
      2'b00:   r = (lhs <  rhs);
      2'b01:   r = (lhs <= rhs);
      2'b10:   r = (lhs == rhs);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = T4;
      T4:      state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state_q == IDLE) && Start;
    in_t1    = (state_q == T1);
    in_t2    = (state_q == T2);
    in_t3    = (state_q == T3);
    in_t4    = (state_q == T4);
    in_final = (state_q == FINAL);
    Busy     = (state_q != IDLE);
  end

  // Datapath: every register is cleared by the asynchronous reset so an abandoned run leaves no trace.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      mode_q <= '0;
      d_q    <= '0;
      f_q    <= '0;
      zrin_q <= '0;
      g_q    <= 1'b0;
      z_q    <= '0;
      x_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= in_final;
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        c_q    <= c;
        mode_q <= Mode;
        if (REG_OUT == 1'b0) begin
          z_q <= '0;
          x_q <= '0;
        end
      end
      if (in_t1) begin
        d_q    <= a_q + b_q;
        f_q    <= a_q * c_q;
        zrin_q <= a_q + c_q;
        g_q    <= cond(mode_q, a_q, b_q);
      end
      if (in_t2 && g_q) zrin_q <= a_q + b_q;
      if (in_t3) z_q <= zrin_q + f_q;
      if (in_t4) x_q <= f_q - d_q;
    end
  end

  assign Done = done_q;
  assign z    = z_q;
  assign x    = x_q;

endmodule
